wb_arb: RTL

WB_ARB -- requirements
Module: wb_arb

---
 rtl/wb_arb_if.sv | 34 +++
 rtl/wb_arb.sv | 131 +++++++++++++
 2 files changed

// File: rtl/wb_arb_if.sv
// Write-back arbiter bus: per-channel producer handshakes in, register-file write port out.
// master = producers/bench side, slave = arbiter side.
interface wb_arb_if #(
    parameter int XLEN = 64,
    parameter int NCH  = 3
);
    localparam int CW = $clog2(NCH);

    logic [NCH-1:0]      in_valid;
    logic [NCH-1:0]      in_ready;
    logic [NCH-1:0]      in_wen;
    logic [NCH*5-1:0]    in_rd;
    logic [NCH*XLEN-1:0] in_data;
    logic                o_RegWr_en;
    logic [4:0]          o_RegWaddr;
    logic [XLEN-1:0]     o_RegWdata;
    logic                o_commit;
    logic [CW-1:0]       o_commit_ch;
    logic                wb_idle;
    logic [63:0]         perf_retired;
    logic [31:0]         perf_stall;

    modport master (
        output in_valid, in_wen, in_rd, in_data,
        input  in_ready, o_RegWr_en, o_RegWaddr, o_RegWdata, o_commit, o_commit_ch,
               wb_idle, perf_retired, perf_stall
    );

    modport slave (
        input  in_valid, in_wen, in_rd, in_data,
        output in_ready, o_RegWr_en, o_RegWaddr, o_RegWdata, o_commit, o_commit_ch,
               wb_idle, perf_retired, perf_stall
    );
endinterface

// File: rtl/wb_arb.sv
// Round-robin write-back arbiter: per-channel FIFOs, one retire per cycle into the register file.
// Optional performance counters enabled by defining WB_ARB_PERF_EN.
module wb_arb_q #(
    parameter int W     = 70,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_head
);
    localparam int AW = $clog2(DEPTH);

    // Extra MSB on each pointer separates full from empty.
    logic [AW:0]  r_wptr, r_rptr;
    logic [W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end

    assign o_empty = (r_wptr == r_rptr);
    assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_head  = r_mem[r_rptr[AW-1:0]];
endmodule

module wb_arb #(
    parameter int XLEN   = 64,
    parameter int NCH    = 3,
    parameter int QDEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    wb_arb_if.slave  bus
);
    localparam int CW = $clog2(NCH);
    localparam int EW = XLEN + 6;

    logic [NCH-1:0]         w_full, w_empty, w_push, w_pop;
    logic [NCH-1:0][EW-1:0] w_head;
    logic [CW-1:0]          r_last_grant;
    logic [CW-1:0]          w_grant, w_idx;
    logic                   w_any, w_commit;
    logic [EW-1:0]          w_sel;
    logic                   w_sel_wen;
    logic [4:0]             w_sel_rd;

    // Ready depends only on occupancy, so a full queue refuses even while it pops.
    generate
        for (genvar g = 0; g < NCH; g++) begin : g_ch
            assign w_push[g] = bus.in_valid[g] & ~w_full[g];
            wb_arb_q #(.W(EW), .DEPTH(QDEPTH)) u_q (
                .clk     (clk),
                .rst     (rst),
                .i_push  (w_push[g]),
                .i_data  ({bus.in_wen[g], bus.in_rd[5*g +: 5], bus.in_data[XLEN*g +: XLEN]}),
                .i_pop   (w_pop[g]),
                .o_full  (w_full[g]),
                .o_empty (w_empty[g]),
                .o_head  (w_head[g])
            );
        end
    endgenerate

    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 1; k <= NCH; k++) begin
            w_idx = CW'((int'(r_last_grant) + k) % NCH);
            if (!w_any && !w_empty[w_idx]) begin
                w_any   = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    assign w_commit  = w_any & ~rst;
    assign w_pop     = w_commit ? (NCH'(1) << w_grant) : '0;
    assign w_sel     = w_head[w_grant];
    assign w_sel_wen = w_sel[EW-1];
    assign w_sel_rd  = w_sel[EW-2 -: 5];

    always_ff @(posedge clk) begin
        if (rst)           r_last_grant <= CW'(NCH - 1);
        else if (w_commit) r_last_grant <= w_grant;
    end

    assign bus.in_ready    = rst ? '1 : ~w_full;
    assign bus.o_commit    = w_commit;
    assign bus.o_commit_ch = w_commit ? w_grant : '0;
    assign bus.o_RegWr_en  = w_commit & w_sel_wen & (|w_sel_rd);
    assign bus.o_RegWaddr  = w_commit ? w_sel_rd : 5'd0;
    assign bus.o_RegWdata  = w_commit ? w_sel[XLEN-1:0] : '0;
    assign bus.wb_idle     = rst | (&w_empty);

`ifdef WB_ARB_PERF_EN
    logic [63:0] r_perf_retired;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_retired <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_commit) r_perf_retired <= r_perf_retired + 64'd1;
            if (|(bus.in_valid & ~bus.in_ready)) r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign bus.perf_retired = r_perf_retired;
    assign bus.perf_stall   = r_perf_stall;
`else
    assign bus.perf_retired = '0;
    assign bus.perf_stall   = '0;
`endif
endmodule
